// File: rtl/ifu_fetch_buf.sv
// Instruction fetch unit with an in-order prefetch buffer between PC generation and decode.
// Sequential fetch requests fill a circular buffer; redirects flush it and discard stale replies.
module ifu_fetch_buf #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_snxt_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  pc_d    [DEPTH];
    logic [ILEN-1:0]  instr_q [DEPTH];
    logic [ILEN-1:0]  instr_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    ptr_t             head_q, head_d;
    ptr_t             fill_q, fill_d;
    ptr_t             alloc_q, alloc_d;
    cnt_t             count_q, count_d;
    cnt_t             pending_q, pending_d;
    cnt_t             discard_q, discard_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;

    logic issue;
    logic pop;
    logic resp_take;
    logic resp_write;

    // Outputs are forced quiet while rstn is low, before the synchronous reset lands.
    assign req_valid  = rstn && !redirect && (count_q < FULL) && (pending_q < FULL);
    assign req_addr   = fetch_pc_q;
    assign out_valid  = rstn && (count_q != '0) && filled_q[head_q];
    assign out_pc      = out_valid ? pc_q[head_q] : '0;
    assign out_instr   = out_valid ? instr_q[head_q] : '0;
    assign out_snxt_pc = out_valid ? pc_q[head_q] + XLEN'(4) : '0;

    assign issue      = req_valid && req_ready;
    assign pop        = out_valid && out_ready && !redirect;
    assign resp_take  = resp_valid && (pending_q != '0);
    assign resp_write = resp_take && (discard_q == '0) && !redirect;

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        filled_d   = filled_q;
        head_d     = head_q;
        fill_d     = fill_q;
        alloc_d    = alloc_q;
        count_d    = count_q;
        pending_d  = pending_q;
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;

        if (redirect) begin
            // Every request still in flight after this cycle belongs to the old stream.
            filled_d   = '0;
            head_d     = '0;
            fill_d     = '0;
            alloc_d    = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
            pending_d  = pending_q - cnt_t'(resp_take);
            discard_d  = pending_q - cnt_t'(resp_take);
        end else begin
            if (issue) begin
                pc_d[alloc_q]     = fetch_pc_q;
                filled_d[alloc_q] = 1'b0;
                alloc_d           = alloc_q + ptr_t'(1);
                fetch_pc_d        = fetch_pc_q + XLEN'(4);
            end
            if (resp_take && (discard_q != '0)) begin
                discard_d = discard_q - cnt_t'(1);
            end
            if (resp_write) begin
                instr_d[fill_q]  = resp_instr;
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + ptr_t'(1);
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + ptr_t'(1);
            end
            count_d   = count_q + cnt_t'(issue) - cnt_t'(pop);
            pending_d = pending_q + cnt_t'(issue) - cnt_t'(resp_take);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q   <= '0;
            head_q     <= '0;
            fill_q     <= '0;
            alloc_q    <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            discard_q  <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            filled_q   <= filled_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            alloc_q    <= alloc_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Directed bench for ifu_fetch_buf: a table of per-cycle vectors plus a streaming sequence.
module tb_ifu_fetch_buf;

    localparam logic [63:0] A = 64'h0000_0000_8000_0000;
    localparam logic [63:0] B = 64'h0000_0000_8000_1000;
    localparam logic [63:0] C = 64'h0000_0000_8000_2000;
    localparam logic [63:0] D = 64'h0000_0000_8000_3000;
    localparam logic [63:0] R = 64'h0000_0000_8000_4000;
    localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [63:0] out_snxt_pc;

    always #5 clk = ~clk;

    ifu_fetch_buf #(
        .XLEN(64),
        .ILEN(32),
        .DEPTH(4),
        .RESET_PC(64'h8000_0000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_valid(resp_valid),
        .resp_instr(resp_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_snxt_pc(out_snxt_pc)
    );

    typedef struct {
        logic        v_rstn;
        logic        v_redir;
        logic [63:0] v_rpc;
        logic        v_rr;
        logic        v_rv;
        logic [31:0] v_ri;
        logic        v_or;
        logic        e_rv;
        logic        ca;
        logic [63:0] e_addr;
        logic        e_ov;
        logic        zc;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reset cycle: request/response/pop all asserted, everything must stay quiet.
    function automatic vec_t mk_rst();
        vec_t v;
        v = '{v_rstn: 1'b0, v_redir: 1'b0, v_rpc: 64'h0, v_rr: 1'b1, v_rv: 1'b1,
              v_ri: 32'hDEAD_0000, v_or: 1'b1, e_rv: 1'b0, ca: 1'b0, e_addr: 64'h0,
              e_ov: 1'b0, zc: 1'b1, e_pc: 64'h0, e_instr: 32'h0};
        return v;
    endfunction

    function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] ri,
                                input logic ordy, input logic erv, input logic [63:0] ea,
                                input logic eov, input logic [63:0] epc,
                                input logic [31:0] ei);
        vec_t v;
        v = '{v_rstn: 1'b1, v_redir: 1'b0, v_rpc: 64'h0, v_rr: rr, v_rv: rv, v_ri: ri,
              v_or: ordy, e_rv: erv, ca: 1'b1, e_addr: ea, e_ov: eov, zc: 1'b0,
              e_pc: epc, e_instr: ei};
        return v;
    endfunction

    // Cycle in reset state: request offered, buffer empty, output data zero.
    function automatic vec_t mkz(input logic rr, input logic rv, input logic [31:0] ri,
                                 input logic ordy, input logic [63:0] ea);
        vec_t v;
        v    = mk(rr, rv, ri, ordy, 1'b1, ea, 1'b0, 64'h0, 32'h0);
        v.zc = 1'b1;
        return v;
    endfunction

    function automatic vec_t mkr(input logic [63:0] rpc, input logic rr, input logic rv,
                                 input logic [31:0] ri, input logic ordy,
                                 input logic [63:0] ea, input logic eov,
                                 input logic [63:0] epc, input logic [31:0] ei);
        vec_t v;
        v         = mk(rr, rv, ri, ordy, 1'b0, ea, eov, epc, ei);
        v.v_redir = 1'b1;
        v.v_rpc   = rpc;
        return v;
    endfunction

    task automatic apply(input string name, input vec_t v);
        logic        ok;
        logic [63:0] e_snxt;
        @(negedge clk);
        rstn        = v.v_rstn;
        redirect    = v.v_redir;
        redirect_pc = v.v_rpc;
        req_ready   = v.v_rr;
        resp_valid  = v.v_rv;
        resp_instr  = v.v_ri;
        out_ready   = v.v_or;
        #1;
        e_snxt = v.e_ov ? v.e_pc + 64'd4 : 64'h0;
        ok = (req_valid === v.e_rv) && (out_valid === v.e_ov);
        if (v.ca && (req_addr !== v.e_addr)) ok = 1'b0;
        if ((v.e_ov || v.zc) && ((out_pc !== v.e_pc) || (out_instr !== v.e_instr) ||
                                 (out_snxt_pc !== e_snxt))) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got rv=%b addr=%h ov=%b pc=%h instr=%h snxt=%h; want rv=%b addr=%h ov=%b pc=%h instr=%h snxt=%h",
                     name, req_valid, req_addr, out_valid, out_pc, out_instr, out_snxt_pc,
                     v.e_rv, v.e_addr, v.e_ov, v.e_pc, v.e_instr, e_snxt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int   resp_k;
        int   del_k;
        int   iss;
        logic acc_prev;

        rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_instr = '0; out_ready = 1'b0;

        // Streaming, then a mid-stream reset with a stray response afterwards.
        vecs.push_back(mk_rst());
        vecs.push_back(mk_rst());
        vecs.push_back(mkz(1, 0, 32'h0, 1, A));
        vecs.push_back(mk(1, 1, 32'h13, 1, 1, A + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h17, 1, 1, A + 64'h8, 1, A, 32'h13));
        vecs.push_back(mk(1, 1, 32'h1B, 1, 1, A + 64'hC, 1, A + 64'h4, 32'h17));
        vecs.push_back(mk(1, 1, 32'h1F, 1, 1, A + 64'h10, 1, A + 64'h8, 32'h1B));
        vecs.push_back(mk(1, 1, 32'h23, 1, 1, A + 64'h14, 1, A + 64'hC, 32'h1F));
        vecs.push_back(mk_rst());
        vecs.push_back(mkz(0, 1, 32'hDEAD_BEEF, 1, A));
        vecs.push_back(mkz(0, 0, 32'h0, 1, A));
        // Decode stalled for 10 cycles: only 4 requests issued, then drain in order.
        vecs.push_back(mk(1, 0, 32'h0, 0, 1, A, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h13, 0, 1, A + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h17, 0, 1, A + 64'h8, 1, A, 32'h13));
        vecs.push_back(mk(1, 1, 32'h1B, 0, 1, A + 64'hC, 1, A, 32'h13));
        vecs.push_back(mk(1, 1, 32'h1F, 0, 0, A + 64'h10, 1, A, 32'h13));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 32'h0, 0, 0, A + 64'h10, 1, A, 32'h13));
        vecs.push_back(mk(1, 0, 32'h0, 1, 0, A + 64'h10, 1, A, 32'h13));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, A + 64'h10, 1, A + 64'h4, 32'h17));
        vecs.push_back(mk(1, 1, 32'h23, 1, 1, A + 64'h14, 1, A + 64'h8, 32'h1B));
        vecs.push_back(mk(1, 1, 32'h27, 1, 1, A + 64'h18, 1, A + 64'hC, 32'h1F));
        vecs.push_back(mk(1, 1, 32'h2B, 1, 1, A + 64'h1C, 1, A + 64'h10, 32'h23));
        // Redirect with 3 requests in flight: their responses are dropped.
        vecs.push_back(mk_rst());
        vecs.push_back(mkz(1, 0, 32'h0, 1, A));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, A + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, A + 64'h8, 0, 64'h0, 32'h0));
        vecs.push_back(mkr(B, 0, 0, 32'h0, 1, A + 64'hC, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 1, 32'hBAD0, 1, 1, B, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'hBAD4, 1, 1, B + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'hBAD8, 1, 1, B + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h1000_0013, 1, 1, B + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, B + 64'h4, 1, B, 32'h1000_0013));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, B + 64'h4, 0, 64'h0, 32'h0));
        // Redirect coinciding with a response and a pop attempt.
        vecs.push_back(mk_rst());
        vecs.push_back(mkz(1, 0, 32'h0, 0, A));
        vecs.push_back(mk(1, 1, 32'h13, 0, 1, A + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0, 0, 1, A + 64'h8, 1, A, 32'h13));
        vecs.push_back(mkr(R, 1, 1, 32'h17, 1, A + 64'hC, 1, A, 32'h13));
        vecs.push_back(mk(1, 1, 32'h1B, 1, 1, R, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h4000_0013, 1, 1, R + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, R + 64'h4, 1, R, 32'h4000_0013));
        // Back-to-back redirects with 2 pending.
        vecs.push_back(mk_rst());
        vecs.push_back(mkz(1, 0, 32'h0, 1, A));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, A + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mkr(C, 1, 0, 32'h0, 1, A + 64'h8, 0, 64'h0, 32'h0));
        vecs.push_back(mkr(D, 1, 1, 32'hBAD0, 1, C, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, D, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 1, 32'hBAD4, 1, 1, D + 64'h4, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h3000_0013, 0, 1, D + 64'h8, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h3000_0017, 1, 1, D + 64'h8, 1, D, 32'h3000_0013));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, D + 64'h8, 1, D + 64'h4, 32'h3000_0017));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, D + 64'h8, 0, 64'h0, 32'h0));
        // Fetch PC wraps past the top of the address space.
        vecs.push_back(mk_rst());
        vecs.push_back(mkr(W, 1, 0, 32'h0, 1, A, 0, 64'h0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0, 1, 1, W, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h55, 1, 1, 64'h0, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 64'h0, 1, W, 32'h55));

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // Streaming with a single-cycle memory: one instruction per cycle once filled.
        apply("stream_rst", mk_rst());
        acc_prev = 1'b0; resp_k = 0; del_k = 0; iss = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rstn = 1'b1; redirect = 1'b0; req_ready = 1'b1; out_ready = 1'b1;
            resp_valid = acc_prev;
            resp_instr = 32'h13 + 32'(4 * resp_k);
            #1;
            if (req_valid) begin
                n_vec++;
                if (req_addr !== A + 64'(4 * iss)) begin
                    n_miss++;
                    $display("FAIL stream_addr%0d: got %h want %h", iss, req_addr, A + 64'(4 * iss));
                end
                iss++;
            end
            if (out_valid) begin
                n_vec++;
                if ((out_pc !== A + 64'(4 * del_k)) || (out_instr !== 32'h13 + 32'(4 * del_k)) ||
                    (out_snxt_pc !== A + 64'(4 * del_k + 4))) begin
                    n_miss++;
                    $display("FAIL stream_out%0d: got pc=%h instr=%h snxt=%h want pc=%h instr=%h snxt=%h",
                             del_k, out_pc, out_instr, out_snxt_pc, A + 64'(4 * del_k),
                             32'h13 + 32'(4 * del_k), A + 64'(4 * del_k + 4));
                end
                del_k++;
            end
            if (resp_valid) resp_k++;
            acc_prev = req_valid;
        end
        n_vec++;
        if (del_k != 22) begin
            n_miss++;
            $display("FAIL stream_rate: got %0d deliveries want 22", del_k);
        end
        n_vec++;
        if (iss != 24) begin
            n_miss++;
            $display("FAIL stream_issue: got %0d requests want 24", iss);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
